// File: rtl/hack_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hack_ram_arbiter
//  Purpose  : Shares the single-port Hack data RAM between the CPU data port
//             (port 0) and a second master (port 1). Each access runs
//             IDLE -> ACCESS -> DONE with a one-cycle ack pulse in DONE.
//  Ports    : clk, rst (sync, active-low)
//             req0/1, we0/1, addr0/1, wdata0/1  - requester inputs
//             ack0/1, rdata0/1                  - requester responses
//             gnt                               - one-hot current owner
//             ram_addr, ram_din, ram_we         - registered RAM controls
//             ram_dout                          - RAM read data (comb.)
//  Config   : HACK_ARB_RR_EN defined   -> round-robin on contention
//             HACK_ARB_RR_EN undefined -> fixed priority, port 0 wins
//  Revision : 1.0 - initial release
// ============================================================================
module hack_ram_arbiter #(
  parameter int M  = 16,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [M-1:0]  wdata0,
  input  logic [M-1:0]  wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [M-1:0]  rdata0,
  output logic [M-1:0]  rdata1,
  output logic [1:0]    gnt,
  output logic [AW-1:0] ram_addr,
  output logic [M-1:0]  ram_din,
  output logic          ram_we,
  input  logic [M-1:0]  ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [1:0]    gnt_nxt;
  logic [AW-1:0] addr_nxt;
  logic [M-1:0]  din_nxt;
  logic          we_nxt;
  logic          ack0_nxt, ack1_nxt;
  logic [M-1:0]  rdata0_nxt, rdata1_nxt;
  logic          pick1;

  // Winner selection: a lone requester always wins; on contention the
  // configured policy decides.
`ifdef HACK_ARB_RR_EN
  assign pick1 = req1 & (~req0 | ~last);
`else
  assign pick1 = req1 & ~req0;
`endif

  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    gnt_nxt    = gnt;
    addr_nxt   = ram_addr;
    din_nxt    = ram_din;
    we_nxt     = 1'b0;
    ack0_nxt   = 1'b0;
    ack1_nxt   = 1'b0;
    rdata0_nxt = rdata0;
    rdata1_nxt = rdata1;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nxt = ACCESS;
          last_nxt  = pick1;
          gnt_nxt   = pick1 ? 2'b10 : 2'b01;
          addr_nxt  = pick1 ? addr1 : addr0;
          din_nxt   = pick1 ? wdata1 : wdata0;
          we_nxt    = pick1 ? we1 : we0;
        end
      end
      ACCESS: begin
        // RAM sees the registered controls this cycle; read data is
        // captured on the closing edge, writes leave rdata untouched.
        state_nxt = DONE;
        ack0_nxt  = gnt[0];
        ack1_nxt  = gnt[1];
        if (!ram_we) begin
          if (gnt[0]) rdata0_nxt = ram_dout;
          if (gnt[1]) rdata1_nxt = ram_dout;
        end
      end
      DONE: begin
        // Requests are ignored here so a held req becomes a fresh
        // transaction only in the following IDLE cycle.
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt      <= 2'b00;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      gnt      <= gnt_nxt;
      ram_addr <= addr_nxt;
      ram_din  <= din_nxt;
      ram_we   <= we_nxt;
      ack0     <= ack0_nxt;
      ack1     <= ack1_nxt;
      rdata0   <= rdata0_nxt;
      rdata1   <= rdata1_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hack_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hack_ram_arbiter
//  Purpose  : Self-checking bench for hack_ram_arbiter. A transaction-level
//             model (grant time, winner, sparse memory) predicts every output
//             each cycle; directed sections pin the model with literals, then
//             randomized requesters exercise the arbiter.
//  Ports    : none (top-level bench)
//  Config   : HACK_ARB_RR_EN selects the round-robin expectations
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hack_ram_arbiter;
  localparam int M  = 16;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [M-1:0]  wdata0, wdata1;
  logic          ack0, ack1;
  logic [M-1:0]  rdata0, rdata1;
  logic [1:0]    gnt;
  logic [AW-1:0] ram_addr;
  logic [M-1:0]  ram_din;
  logic          ram_we;
  logic [M-1:0]  ram_dout;

  always #5 clk = ~clk;

  // Behavioural single-port RAM: combinational read, write on clock edge.
  logic [M-1:0] ram [0:(1<<AW)-1];
  assign ram_dout = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;

  hack_ram_arbiter #(.M(M), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .gnt(gnt), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Transaction-level model: the last grant's edge, winner and payload.
  logic [M-1:0]  mm [int];
  int            g = -10;
  int            nxt = 0;
  logic          tw = 1'b0, twe = 1'b1, mlast = 1'b1;
  logic [M-1:0]  tval = '0;
  logic [AW-1:0] e_addr = '0;
  logic [M-1:0]  e_din = '0, e_rd0 = '0, e_rd1 = '0;

  logic [AW-1:0] pool [8] = '{15'h0000, 15'h0001, 15'h0010, 15'h00FF,
                              15'h1234, 15'h4000, 15'h7FFE, 15'h7FFF};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Predict the effect of the upcoming edge from the inputs now applied.
  task automatic predict();
    int e;
    logic [AW-1:0] a;
    logic [M-1:0] dv;
    e = cyc + 1;
    if (!rst) begin
      g = -10; nxt = e + 1; mlast = 1'b1;
      e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      if (e == g + 1 && !twe) begin
        if (tw) e_rd1 = tval; else e_rd0 = tval;
      end
      if (e >= nxt && (req0 || req1)) begin
`ifdef HACK_ARB_RR_EN
        if (req0 && req1) tw = !mlast; else tw = req1;
`else
        if (req0 && req1) tw = 1'b0; else tw = req1;
`endif
        twe = tw ? we1 : we0;
        a   = tw ? addr1 : addr0;
        dv  = tw ? wdata1 : wdata0;
        if (twe) mm[int'(a)] = dv;
        else tval = mm.exists(int'(a)) ? mm[int'(a)] : '0;
        g = e; nxt = e + 3; mlast = tw;
        e_addr = a; e_din = dv;
      end
    end
  endtask

  task automatic compare();
    int d;
    logic [1:0] eg;
    logic ea0, ea1, ewe;
    d = cyc - g;
    eg = 2'b00; ea0 = 1'b0; ea1 = 1'b0; ewe = 1'b0;
    if (d == 0 || d == 1) eg = tw ? 2'b10 : 2'b01;
    if (d == 0) ewe = twe;
    if (d == 1) begin ea0 = !tw; ea1 = tw; end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("ram_we", 32'(ram_we), 32'(ewe));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_din", 32'(ram_din), 32'(e_din));
    chk("ack0", 32'(ack0), 32'(ea0));
    chk("ack1", 32'(ack1), 32'(ea1));
    chk("rdata0", 32'(rdata0), 32'(e_rd0));
    chk("rdata1", 32'(rdata1), 32'(e_rd1));
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  // Run one directed transaction from an IDLE cycle; reports latency to ack
  // and what the RAM saw while it was in flight. Ends in the IDLE cycle.
  task automatic txn(input int p, input logic w, input logic [AW-1:0] a,
                     input logic [M-1:0] dat, output int lat, output int nwe,
                     output logic [AW-1:0] wa, output logic [M-1:0] wd);
    logic got;
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = dat; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = dat; end
    lat = 0; nwe = 0; wa = '0; wd = '0; got = 1'b0;
    while (!got && lat < 10) begin
      tick();
      lat++;
      if (ram_we) begin nwe++; wa = ram_addr; wd = ram_din; end
      got = (p == 0) ? ack0 : ack1;
    end
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    tick();
  endtask

  initial begin
    int lat, nwe, n0, n1, both, ord, lastack, saw;
    logic [AW-1:0] wa;
    logic [M-1:0] wd;
    logic pend [2];
    logic pwe [2];
    logic [AW-1:0] paddr [2];
    logic [M-1:0] pdat [2];
    logic ackv [2];

    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 15'h0000; addr1 = 15'h0010; wdata0 = '0; wdata1 = '0;

    // Reset held with both requests high.
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'({ack1, ack0}), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_rdata", 32'({rdata1, rdata0}), 32'd0);

    // Contention straight out of reset, both reads held for 12 cycles.
    rst = 1'b1;
    n0 = 0; n1 = 0; both = 0; ord = 0; lastack = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ack0 && ack1) both++;
      if (ack0 || ack1) begin
        if (lastack >= 0) chk("ack_spacing", 32'(cyc - lastack), 32'd3);
        lastack = cyc;
        ord = (ord << 1) | int'(ack1);
      end
      if (ack0) n0++;
      if (ack1) n1++;
    end
    chk("ack_both", 32'(both), 32'd0);
`ifdef HACK_ARB_RR_EN
    chk("rr_n0", 32'(n0), 32'd2);
    chk("rr_n1", 32'(n1), 32'd2);
    chk("rr_order", 32'(ord), 32'b0101);
`else
    chk("fp_n0", 32'(n0), 32'd4);
    chk("fp_n1", 32'(n1), 32'd0);
`endif
    req0 = 1'b0;
    tick();
    chk("drop0_gnt", 32'(gnt), 32'b10);
    tick();
    chk("drop0_ack1", 32'(ack1), 32'd1);
    req1 = 1'b0;
    tick();

    // Port 0 write then read back.
    txn(0, 1'b1, 15'h0010, 16'hBEEF, lat, nwe, wa, wd);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_nwe", 32'(nwe), 32'd1);
    chk("wr_addr", 32'(wa), 32'h0010);
    chk("wr_din", 32'(wd), 32'hBEEF);
    txn(0, 1'b0, 15'h0010, 16'h0000, lat, nwe, wa, wd);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_nwe", 32'(nwe), 32'd0);
    chk("rd_data0", 32'(rdata0), 32'hBEEF);

    // Port 1 reads, then writes the top word; port 0 reads it back.
    txn(1, 1'b0, 15'h0010, 16'h0000, lat, nwe, wa, wd);
    chk("rd_data1", 32'(rdata1), 32'hBEEF);
    txn(1, 1'b1, 15'h7FFF, 16'h1234, lat, nwe, wa, wd);
    chk("wr1_addr", 32'(wa), 32'h7FFF);
    txn(0, 1'b0, 15'h7FFF, 16'h0000, lat, nwe, wa, wd);
    chk("rd_top0", 32'(rdata0), 32'h1234);
    chk("rd1_kept", 32'(rdata1), 32'hBEEF);

    // Reset landing in ACCESS of a port 1 write.
    req1 = 1'b1; we1 = 1'b1; addr1 = 15'h5555; wdata1 = 16'hA5A5;
    tick();
    chk("acc_gnt", 32'(gnt), 32'b10);
    chk("acc_we", 32'(ram_we), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1; req1 = 1'b0;
    chk("racc_gnt", 32'(gnt), 32'd0);
    chk("racc_we", 32'(ram_we), 32'd0);
    chk("racc_ack", 32'(ack1), 32'd0);
    saw = 0;
    repeat (4) begin tick(); if (ack1) saw++; end
    chk("racc_noack", 32'(saw), 32'd0);

    // Randomized requesters following the hold-until-ack protocol.
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = '0; pdat[p] = '0;
    end
    for (int i = 0; i < 3000; i++) begin
      ackv[0] = ack0; ackv[1] = ack1;
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && ackv[p]) pend[p] = 1'b0;
        if (!pend[p] && $urandom_range(2, 0) == 0) begin
          pend[p]  = 1'b1;
          pwe[p]   = 1'($urandom_range(1, 0));
          paddr[p] = pool[3'($urandom_range(7, 0))];
          pdat[p]  = 16'($urandom);
        end
      end
      req0 = pend[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pdat[0];
      req1 = pend[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pdat[1];
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hack_ram_arbiter.md
# hack_ram_arbiter

Two-requester arbiter that shares the single-port Hack data RAM (M-bit words) between the CPU data port and a second master (loader/DMA/IO engine). It sits between the requesters and the RAM, serialises accesses with a req/ack handshake, and drives the RAM address, data and write-enable. Arbitration is fixed-priority or round-robin, selected at compile time.

## Interface
- M, 16, data word width
- AW, 15, RAM address width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read; held with req
- addr0 / addr1  in  AW  word address; held with req
- wdata0 / wdata1  in  M  write data; held with req
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  M  read data, valid while ackN = 1, held until next ack on that port
- gnt  out  2  one-hot current owner (bit N = port N), 00 when idle
- ram_addr  out  AW  RAM address (registered)
- ram_din  out  M  RAM write data (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_dout  in  M  RAM read data, combinational from ram_addr

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req high, pick winner, register ram_addr/ram_din/ram_we from winner, set gnt, go ACCESS. No request: stay IDLE, ram_we = 0, ram_addr/ram_din hold.
- ACCESS: RAM sees registered controls; write commits at end of this cycle. At its closing edge: capture ram_dout into rdataN (reads only; writes leave rdataN unchanged), set ackN = 1, ram_we = 0, go DONE.
- DONE: ackN high for exactly this cycle; all req inputs ignored; gnt cleared at closing edge; go IDLE.
- Requester holds req/we/addr/wdata stable from assertion until it sees ack. req still high in the IDLE cycle after ack = new transaction.
- Changing we/addr/wdata while req is high and not yet acked: undefined, not checked.
- Both req high in IDLE: winner per Configuration; loser keeps req high and is served next round.
- Only one ack high per cycle; ack0 and ack1 never high together.
- Arbitration pointer `last` (1 bit) = port granted most recently; updated in IDLE on each grant.
- Reset values: state IDLE, ack0 = ack1 = 0, rdata0 = rdata1 = 0, gnt = 00, ram_we = 0, ram_addr = 0, ram_din = 0, last = 1.
- Reset asserted in ACCESS: write presented that cycle may commit in RAM (RAM not reset); no ack issued; state returns to IDLE.

## Timing
- Request sampled at edge E0 (IDLE) -> ram_* valid cycle after E0 (ACCESS) -> ack high in following cycle (DONE).
- Request-to-ack latency: ack rises 2 cycles after the sampling edge.
- Throughput: one access per 3 cycles max (IDLE, ACCESS, DONE); back-to-back same port: ack pulses 3 cycles apart.
- ram_we high for exactly one cycle per write, zero for reads.
- No combinational path from any req/addr input to any output; ram_dout reaches rdataN only through a register.

## Configuration
- HACK_ARB_RR_EN defined: round-robin. On contention, winner = port != last. With single requester it wins regardless of last.
- HACK_ARB_RR_EN undefined: fixed priority, port 0 always wins contention; `last` still maintained but unused. Port 1 may starve under continuous port-0 traffic; accepted.

## Test plan
- Reset: hold rst = 0 for 3 cycles with req0 = req1 = 1 -> all outputs at reset values, no ram_we, no ack.
- Single write then read, port 0: write addr 0x0010 data 0xBEEF -> ram_we one cycle with ram_addr 0x0010, ram_din 0xBEEF, ack0 2 cycles after sampling; read addr 0x0010 -> ack0 with rdata0 = 0xBEEF, ram_we stays 0.
- Contention, fixed priority (macro off): req0 and req1 held high for 12 cycles -> 4 ack0 pulses, 0 ack1 pulses; drop req0 -> port 1 served next IDLE.
- Contention, round-robin (macro on): both held high from reset -> grant order 0,1,0,1 (last = 1 after reset), acks 3 cycles apart, never simultaneous.
- Port 1 write 0x1234 to 0x7FFF then port 0 read 0x7FFF -> rdata0 = 0x1234; rdata1 unchanged by port 0 traffic.
- Reset in ACCESS of a port-1 write -> ack1 never pulses, next cycle state IDLE with gnt = 00, ram_we = 0.
